// File: rtl/rom_ctrl_checker_pkg.sv
// Shared types and geometry helpers for the ROM digest checker.
package rom_ctrl_checker_pkg;

  localparam int DefRomDepth    = 16;
  localparam int DefRomTopCount = 2;
  localparam int DefDataWidth   = 32;

  localparam int NonTopCount  = DefRomDepth - DefRomTopCount;
  localparam int FirstTopAddr = NonTopCount;

  typedef enum logic [2:0] {
    ReadNonTop = 3'd0,
    ReadTop    = 3'd1,
    WaitKmac   = 3'd2,
    Done       = 3'd3,
    Error      = 3'd4
  } checker_state_e;

  function automatic int non_top_count(input int depth, input int top_count);
    return depth - top_count;
  endfunction

endpackage

// File: rtl/rom_ctrl_msg_buf.sv
// Single-entry vld/rdy register stage carrying data and a last flag,
// with a synchronous clear that discards any held beat.
module rom_ctrl_msg_buf #(
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 in_vld_i,
  input  logic [DataWidth-1:0] in_data_i,
  input  logic                 in_last_i,
  output logic                 in_rdy_o,
  output logic                 out_vld_o,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 out_last_o,
  input  logic                 out_rdy_i
);

  logic                 vld_q, vld_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 last_q, last_d;

  // Drain and refill in the same cycle keeps one beat per cycle.
  assign in_rdy_o = ~vld_q | out_rdy_i;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    last_d = last_q;
    if (vld_q && out_rdy_i) begin
      vld_d = 1'b0;
    end
    if (in_vld_i && in_rdy_o) begin
      vld_d  = 1'b1;
      data_d = in_data_i;
      last_d = in_last_i;
    end
    if (clr_i) begin
      vld_d  = 1'b0;
      data_d = '0;
      last_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      last_q <= last_d;
    end
  end

  assign out_vld_o  = vld_q;
  assign out_data_o = data_q;
  assign out_last_o = last_q;

endmodule

// File: rtl/rom_ctrl_rom_checker.sv
// Streams non-top ROM words to KMAC, captures the top words as the expected
// digest and compares it with the digest KMAC returns.
module rom_ctrl_rom_checker
  import rom_ctrl_checker_pkg::*;
#(
  parameter int RomDepth    = DefRomDepth,
  parameter int RomTopCount = DefRomTopCount,
  parameter int DataWidth   = DefDataWidth,
  localparam int AW          = $clog2(RomDepth),
  localparam int DigestWidth = RomTopCount * DataWidth
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rom_vld_i,
  input  logic [AW-1:0]          rom_addr_i,
  input  logic [DataWidth-1:0]   rom_data_i,
  input  logic                   rom_last_nontop_i,
  output logic                   rom_rdy_o,
  output logic                   kmac_vld_o,
  output logic [DataWidth-1:0]   kmac_data_o,
  output logic                   kmac_last_o,
  input  logic                   kmac_rdy_i,
  input  logic                   kmac_done_i,
  input  logic [DigestWidth-1:0] kmac_digest_i,
  output logic [DigestWidth-1:0] exp_digest_o,
  output logic                   check_done_o,
  output logic                   check_good_o,
  output logic                   alert_o
);

  localparam int            NonTop         = non_top_count(RomDepth, RomTopCount);
  localparam logic [AW-1:0] LastNonTopAddr = AW'(NonTop - 1);
  localparam logic [AW-1:0] LastAddr       = AW'(RomDepth - 1);

  checker_state_e         state_q, state_d;
  logic [AW-1:0]          exp_addr_q, exp_addr_d;
  logic [DigestWidth-1:0] exp_digest_q, exp_digest_d;
  logic                   good_q, good_d;

  logic rom_rdy, rom_acc, word_ok;
  logic buf_in_rdy, buf_load, buf_clr;

  always_comb begin
    rom_rdy = 1'b0;
    unique case (state_q)
      ReadNonTop: rom_rdy = buf_in_rdy;
      ReadTop:    rom_rdy = 1'b1;
      default:    rom_rdy = 1'b0;
    endcase
  end

  assign rom_rdy_o = rom_rdy & ~rst_i;
  assign rom_acc   = rom_vld_i & rom_rdy;
  // last_nontop must be asserted exactly at the final non-top address.
  assign word_ok   = (rom_addr_i == exp_addr_q) &&
                     (rom_last_nontop_i == (rom_addr_i == LastNonTopAddr));

  always_comb begin
    state_d      = state_q;
    exp_addr_d   = exp_addr_q;
    exp_digest_d = exp_digest_q;
    good_d       = good_q;
    buf_load     = 1'b0;
    unique case (state_q)
      ReadNonTop: begin
        if (rom_acc) begin
          if (!word_ok) begin
            state_d = Error;
          end else begin
            buf_load   = 1'b1;
            exp_addr_d = exp_addr_q + AW'(1);
            if (rom_last_nontop_i) state_d = ReadTop;
          end
        end
        if (kmac_done_i) state_d = Error;
      end
      ReadTop: begin
        if (rom_acc) begin
          if (!word_ok) begin
            state_d = Error;
          end else begin
            for (int i = 0; i < RomTopCount; i++) begin
              if (rom_addr_i == AW'(NonTop + i)) begin
                exp_digest_d[i*DataWidth +: DataWidth] = rom_data_i;
              end
            end
            // The counter stops at the last address instead of wrapping.
            if (exp_addr_q == LastAddr) state_d = WaitKmac;
            else                        exp_addr_d = exp_addr_q + AW'(1);
          end
        end
        if (kmac_done_i) state_d = Error;
      end
      WaitKmac: begin
        if (kmac_done_i) begin
          if (kmac_vld_o) begin
            state_d = Error;
          end else begin
            state_d = Done;
            good_d  = (kmac_digest_i == exp_digest_q);
          end
        end
      end
      Done:    state_d = Done;
      Error:   state_d = Error;
      default: state_d = Error;
    endcase
  end

  assign buf_clr = (state_d == Error);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ReadNonTop;
      exp_addr_q   <= '0;
      exp_digest_q <= '0;
      good_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_addr_q   <= exp_addr_d;
      exp_digest_q <= exp_digest_d;
      good_q       <= good_d;
    end
  end

  rom_ctrl_msg_buf #(
    .DataWidth(DataWidth)
  ) u_msg_buf (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (buf_clr),
    .in_vld_i   (buf_load),
    .in_data_i  (rom_data_i),
    .in_last_i  (rom_last_nontop_i),
    .in_rdy_o   (buf_in_rdy),
    .out_vld_o  (kmac_vld_o),
    .out_data_o (kmac_data_o),
    .out_last_o (kmac_last_o),
    .out_rdy_i  (kmac_rdy_i)
  );

  assign exp_digest_o = exp_digest_q;
  assign check_done_o = (state_q == Done) || (state_q == Error);
  assign check_good_o = (state_q == Done) && good_q;
  assign alert_o      = (state_q == Error);

endmodule

// File: doc/rom_ctrl_rom_checker.md
Name: rom_ctrl_rom_checker

Overview:
- Sits directly downstream of the ROM-read counter.
- Takes ROM words as they are read out in address order.
- Forwards the non-top words to KMAC over a vld/rdy message interface and captures the top RomTopCount words as the expected digest.
- Compares that expected digest against the digest KMAC returns and reports pass/fail plus a sticky protocol-error alert to the surrounding hardened FSM.

Parameters:
- RomDepth, 16, number of ROM words; address width AW = vbits(RomDepth).
- RomTopCount, 2, number of top words holding the expected digest; must satisfy 1 <= RomTopCount < RomDepth - 1.
- DataWidth, 32, ROM word width, ECC already stripped.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- rom_vld_i  in  1  ROM word valid; held stable until accepted.
- rom_addr_i  in  AW  address of the presented word.
- rom_data_i  in  DataWidth  ROM word.
- rom_last_nontop_i  in  1  presented word is address RomDepth-RomTopCount-1.
- rom_rdy_o  out  1  word accepted when rom_vld_i & rom_rdy_o.
- kmac_vld_o  out  1  message beat valid.
- kmac_data_o  out  DataWidth  message beat.
- kmac_last_o  out  1  final message beat.
- kmac_rdy_i  in  1  KMAC accepts beat.
- kmac_done_i  in  1  single-cycle pulse: digest valid.
- kmac_digest_i  in  RomTopCount*DataWidth  computed digest, word 0 in LSBs.
- exp_digest_o  out  RomTopCount*DataWidth  captured expected digest.
- check_done_o  out  1  comparison finished (sticky).
- check_good_o  out  1  digests matched; valid only with check_done_o.
- alert_o  out  1  protocol error (sticky until reset).

Behaviour:
- Reset is synchronous and active-high on rst_i, clocked by clk_i. When rst_i is sampled high:
  - all outputs are 0, exp_digest_o is 0;
  - the FSM goes to ReadNonTop and the expected-address counter exp_addr_q resets to 0.
  - Reset mid-operation aborts everything the same way; no residue remains.
- FSM states: ReadNonTop, ReadTop, WaitKmac, Done, Error.
- Output buffer: single entry (buf_vld_q, buf_data_q, buf_last_q) drives kmac_*_o directly from flops.
- ReadNonTop:
  - rom_rdy_o = ~buf_vld_q | kmac_rdy_i.
  - On accept: the buffer loads rom_data_i and buf_last_q = rom_last_nontop_i; exp_addr_q increments.
  - The beat appears on kmac_data_o the next cycle (latency 1).
  - A simultaneous drain and load in the same cycle gives full throughput of one word per cycle.
  - On accepting the word with rom_last_nontop_i = 1, go to ReadTop.
- ReadTop:
  - rom_rdy_o = 1.
  - Each accepted word is written to exp_digest word index (rom_addr_i - (RomDepth-RomTopCount)); exp_addr_q increments.
  - After RomTopCount top words have been accepted, go to WaitKmac.
  - The buffer keeps draining independently.
- Address check, in ReadNonTop and ReadTop: on any accept with rom_addr_i != exp_addr_q, go to Error.
- rom_last_nontop_i check: asserted at the wrong address, or deasserted at address RomDepth-RomTopCount-1 -> Error.
- WaitKmac:
  - rom_rdy_o = 0.
  - On kmac_done_i with buffer empty: compare kmac_digest_i to exp_digest, set check_done_o, set check_good_o = equal, go to Done.
  - kmac_done_i while buf_vld_q = 1 (including the cycle the last beat handshakes) -> Error.
- kmac_done_i in ReadNonTop or ReadTop -> Error.
- Done:
  - Terminal; rom_rdy_o = 0, kmac_vld_o = 0; results are held.
  - Further kmac_done_i pulses are ignored.
- Error:
  - Terminal until reset.
  - alert_o = 1, check_done_o = 1, check_good_o = 0, rom_rdy_o = 0.
  - The buffer is cleared (kmac_vld_o = 0).
- rom_vld_i = 1 in WaitKmac, Done or Error is ignored; it is not an error.
- exp_addr_q is AW bits wide and never wraps: the FSM stops accepting at RomDepth-1.
- A non-matching digest does not raise alert_o; failure is reported via check_good_o only.

Decomposition:
- Package rom_ctrl_checker_pkg holds:
  - state enum checker_state_e (explicit encoding, 3 bits);
  - localparams NonTopCount = RomDepth-RomTopCount and FirstTopAddr.
- Sub-module rom_ctrl_msg_buf: single-entry vld/rdy register stage with data and last, plus a synchronous clear input used on entry to Error.

Test Plan (RomDepth=16, RomTopCount=2, DataWidth=32):
- Nominal, kmac_rdy_i always 1:
  - present words addr 0..15 with data = addr*0x11111111, last_nontop at addr 13;
  - kmac_done_i with digest {0xFFFFFFFF,0xEEEEEEEE} after beat 13;
  - expect 14 beats, kmac_last_o only on beat 13, exp_digest_o = {0xFFFFFFFF,0xEEEEEEEE}, check_done_o=1, check_good_o=1, alert_o=0.
- Backpressure, kmac_rdy_i toggled 1-0-1:
  - expect rom_rdy_o low exactly when the buffer is full and kmac_rdy_i=0;
  - no beat dropped or duplicated; order 0..13 preserved.
- Digest mismatch (kmac_digest_i word 1 = 0xFFFFFFFE): check_done_o=1, check_good_o=0, alert_o=0.
- Address skip (present addr 5 when 4 expected): next cycle alert_o=1, kmac_vld_o=0, rom_rdy_o=0; state remains until rst_i.
- Premature done (kmac_done_i during the beat-13 handshake cycle): alert_o=1, check_good_o=0.
- Mid-run reset (rst_i high for one cycle after addr 7, then a full nominal sequence): all outputs 0 during reset; second run passes as in the nominal test.
